// File: rtl/bigdiv_pkg.sv
// Shared types and default formats for the bigdiv fixed-point divider.
package bigdiv_pkg;

  localparam int INT_IN_DEF   = 10;
  localparam int FRAC_IN_DEF  = 22;
  localparam int INT_DIV_DEF  = 1;
  localparam int FRAC_DIV_DEF = 11;
  localparam int INT_OUT_DEF  = 21;
  localparam int FRAC_OUT_DEF = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bigdiv_div_step.sv
// One radix-2 restoring step: shift a dividend bit into the partial remainder,
// subtract the divisor when it fits, and report the quotient bit.
module div_step #(
  parameter int dvs_w_p = 12
) (
  input  logic [dvs_w_p:0]   part_rem,
  input  logic               dvd_bit,
  input  logic [dvs_w_p-1:0] divisor,
  output logic [dvs_w_p:0]   next_rem,
  output logic               q_bit
);

  logic [dvs_w_p+1:0] shifted_s;
  logic [dvs_w_p:0]   diff_s;

  // Trial subtraction; the remainder is restored by simply keeping the shifted value.
  always_comb begin
    shifted_s = {part_rem, dvd_bit};
    diff_s    = shifted_s[dvs_w_p:0] - {1'b0, divisor};
    if (shifted_s >= {2'b00, divisor}) begin
      next_rem = diff_s;
      q_bit    = 1'b1;
    end else begin
      next_rem = shifted_s[dvs_w_p:0];
      q_bit    = 1'b0;
    end
  end

endmodule

// File: rtl/bigdiv.sv
// Unsigned fixed-point divider: one quotient bit per cycle, MSB first, with a
// ready/valid handshake on both sides and divide-by-zero flagging.
module bigdiv
  import bigdiv_pkg::*;
#(
  parameter int int_in_lp   = INT_IN_DEF,
  parameter int frac_in_lp  = FRAC_IN_DEF,
  parameter int int_div_lp  = INT_DIV_DEF,
  parameter int frac_div_lp = FRAC_DIV_DEF,
  parameter int int_out_lp  = INT_OUT_DEF,
  parameter int frac_out_lp = FRAC_OUT_DEF
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [int_in_lp-1:-frac_in_lp]    a_i,
  input  logic [int_div_lp-1:-frac_div_lp]  b_i,
  input  logic                              valid_i,
  output logic                              ready_o,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [int_out_lp-1:-frac_out_lp]  data_o,
  output logic [int_div_lp-1:-frac_div_lp]  rem_o,
  output logic                              dbz_o
);

  localparam int W     = int_in_lp + frac_in_lp;
  localparam int WB    = int_div_lp + frac_div_lp;
  localparam int QW    = int_out_lp + frac_out_lp;
  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(W - 1);

  state_e           state_r;
  state_e           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [W-1:0]     dvd_r;
  logic [WB-1:0]    dvs_r;
  logic [WB:0]      rem_r;
  logic [QW-1:0]    data_r;
  logic [WB-1:0]    remo_r;
  logic             dbz_r;
  logic             valid_r;

  logic [W-1:0]     a_s;
  logic [WB-1:0]    b_s;
  logic             b_zero_s;
  logic             ready_s;
  logic             accept_s;
  logic [WB:0]      next_rem_s;
  logic             q_bit_s;

  assign a_s      = a_i;
  assign b_s      = b_i;
  assign b_zero_s = (b_s == {WB{1'b0}});

  div_step #(.dvs_w_p(WB)) u_step (
    .part_rem (rem_r),
    .dvd_bit  (dvd_r[W-1]),
    .divisor  (dvs_r),
    .next_rem (next_rem_s),
    .q_bit    (q_bit_s)
  );

  // Handshake on the input side; DONE passes ready through from downstream.
  always_comb begin
    ready_s = 1'b0;
    case (state_r)
      IDLE:    ready_s = 1'b1;
      BUSY:    ready_s = 1'b0;
      DONE:    ready_s = ready_i;
      default: ready_s = 1'b0;
    endcase
    accept_s = valid_i & ready_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = b_zero_s ? DONE : BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_s = DONE;
        end else begin
          state_s = BUSY;
        end
      end
      DONE: begin
        if (accept_s) begin
          state_s = b_zero_s ? DONE : BUSY;
        end else if (ready_i) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Datapath, counter and registered result; results persist until replaced.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      dvd_r   <= {W{1'b0}};
      dvs_r   <= {WB{1'b0}};
      rem_r   <= {(WB+1){1'b0}};
      data_r  <= {QW{1'b0}};
      remo_r  <= {WB{1'b0}};
      dbz_r   <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        dvd_r <= a_s;
        dvs_r <= b_s;
        rem_r <= {(WB+1){1'b0}};
        if (b_zero_s) begin
          cnt_r   <= {CNT_W{1'b0}};
          data_r  <= {QW{1'b1}};
          remo_r  <= {WB{1'b0}};
          dbz_r   <= 1'b1;
          valid_r <= 1'b1;
        end else begin
          cnt_r   <= CNT_LOAD;
          valid_r <= 1'b0;
        end
      end else if (state_r == BUSY) begin
        rem_r <= next_rem_s;
        // Quotient bits fill the dividend register from the bottom as it drains.
        dvd_r <= {dvd_r[W-2:0], q_bit_s};
        if (cnt_r == {CNT_W{1'b0}}) begin
          data_r  <= QW'({dvd_r[W-2:0], q_bit_s});
          remo_r  <= next_rem_s[WB-1:0];
          dbz_r   <= 1'b0;
          valid_r <= 1'b1;
        end else begin
          cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end else if ((state_r == DONE) && ready_i) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign ready_o = ready_s;
  assign valid_o = valid_r;
  assign data_o  = data_r;
  assign rem_o   = remo_r;
  assign dbz_o   = dbz_r;

endmodule

// File: tb/tb_bigdiv.sv
// Self-checking bench for bigdiv: directed latency/value cases, stall hold,
// mid-operation reset and a random scoreboarded stream.
module tb_bigdiv;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [31:0] a_i = 32'd0;
  logic [11:0] b_i = 12'd0;
  logic        valid_i = 1'b0;
  logic        ready_i = 1'b0;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] data_o;
  logic [11:0] rem_o;
  logic        dbz_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] q;
    logic [11:0] r;
    logic        dbz;
  } res_t;

  res_t exp_q[$];

  bigdiv dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .rem_o   (rem_o),
    .dbz_o   (dbz_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic res_t model(input logic [31:0] a, input logic [11:0] b);
    res_t r;
    logic [31:0] m;
    if (b == 12'd0) begin
      r.q = 32'hFFFF_FFFF; r.r = 12'd0; r.dbz = 1'b1;
    end else begin
      r.q = a / {20'd0, b};
      m   = a % {20'd0, b};
      r.r = m[11:0];
      r.dbz = 1'b0;
    end
    return r;
  endfunction

  task automatic test_reset();
    @(negedge clk_i);
    reset_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_o); end
    checks++; if (data_o !== 32'd0) begin errors++; $display("FAIL reset_data got %h want 0", data_o); end
    checks++; if (rem_o !== 12'd0) begin errors++; $display("FAIL reset_rem got %h want 0", rem_o); end
    checks++; if (dbz_o !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b want 0", dbz_o); end
    reset_i = 1'b0;
    #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready_o); end
  endtask

  task automatic test_basic();
    logic [31:0] ta[6];
    logic [11:0] tbv[6];
    int          tl[6];
    res_t        e;
    res_t        got;
    int          lat;
    ta  = '{32'h0060_0000, 32'hFFFF_FFFF, 32'h0000_0C00, 32'h0000_0000, 32'h1234_5678, 32'hDEAD_BEEF};
    tbv = '{12'h400,       12'h001,       12'h800,       12'h7FF,       12'h000,       12'hFFF};
    tl  = '{33, 33, 33, 33, 1, 33};
    ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      a_i = ta[i]; b_i = tbv[i]; valid_i = 1'b1;
      #1;
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL basic_ready[%0d] got %b want 1", i, ready_o); end
      e = model(ta[i], tbv[i]);
      @(posedge clk_i);
      @(negedge clk_i);
      valid_i = 1'b0;
      lat = 1;
      while (valid_o !== 1'b1 && lat < 100) begin
        @(posedge clk_i); @(negedge clk_i); lat++;
      end
      checks++; if (lat != tl[i]) begin errors++; $display("FAIL basic_latency[%0d] got %0d want %0d", i, lat, tl[i]); end
      got = {data_o, rem_o, dbz_o};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL basic_result[%0d] got q=%h r=%h dbz=%b want q=%h r=%h dbz=%b", i, data_o, rem_o, dbz_o, e.q, e.r, e.dbz);
      end
    end
    @(negedge clk_i);
  endtask

  task automatic test_hold();
    res_t e;
    res_t e2;
    res_t got;
    int   lat;
    ready_i = 1'b0;
    @(negedge clk_i);
    a_i = 32'h0060_0000; b_i = 12'h400; valid_i = 1'b1;
    e = model(a_i, b_i);
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    lat = 1;
    while (valid_o !== 1'b1 && lat < 100) begin
      @(posedge clk_i); @(negedge clk_i); lat++;
    end
    checks++; if (lat != 33) begin errors++; $display("FAIL hold_latency got %0d want 33", lat); end
    // Offer a new pair during the stall; it must be ignored.
    valid_i = 1'b1; a_i = 32'h0000_0001; b_i = 12'h003;
    for (int i = 0; i < 10; i++) begin
      #1;
      got = {data_o, rem_o, dbz_o};
      checks++;
      if (got !== e || valid_o !== 1'b1) begin
        errors++;
        $display("FAIL hold_stable[%0d] got q=%h r=%h dbz=%b v=%b want q=%h r=%h dbz=%b v=1", i, data_o, rem_o, dbz_o, valid_o, e.q, e.r, e.dbz);
      end
      checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d] got %b want 0", i, ready_o); end
      @(posedge clk_i); @(negedge clk_i);
    end
    ready_i = 1'b1; a_i = 32'hFFFF_FFFF; b_i = 12'h001; valid_i = 1'b1;
    e2 = model(a_i, b_i);
    #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL hold_passthru got %b want 1", ready_o); end
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    checks++;
    if (ready_o !== 1'b0 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL hold_no_bubble got ready=%b valid=%b want ready=0 valid=0", ready_o, valid_o);
    end
    lat = 1;
    while (valid_o !== 1'b1 && lat < 100) begin
      @(posedge clk_i); @(negedge clk_i); lat++;
    end
    checks++; if (lat != 33) begin errors++; $display("FAIL hold_next_latency got %0d want 33", lat); end
    got = {data_o, rem_o, dbz_o};
    checks++;
    if (got !== e2) begin
      errors++;
      $display("FAIL hold_next_result got q=%h r=%h dbz=%b want q=%h r=%h dbz=%b", data_o, rem_o, dbz_o, e2.q, e2.r, e2.dbz);
    end
    @(negedge clk_i);
  endtask

  task automatic test_reset_mid();
    int emitted;
    ready_i = 1'b1;
    @(negedge clk_i);
    a_i = 32'h0ABC_DEF0; b_i = 12'h003; valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (14) @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL midreset_ready got %b want 1", ready_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b want 0", valid_o); end
    checks++; if (data_o !== 32'd0) begin errors++; $display("FAIL midreset_data got %h want 0", data_o); end
    emitted = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i); @(negedge clk_i);
      if (valid_o !== 1'b0) emitted++;
    end
    checks++; if (emitted != 0) begin errors++; $display("FAIL midreset_emit got %0d valid cycles want 0", emitted); end
  endtask

  task automatic test_back_to_back();
    int   sent;
    int   recv;
    int   cycles;
    res_t e;
    res_t got;
    sent = 0; recv = 0; cycles = 0;
    exp_q.delete();
    while (recv < 1000 && cycles < 60000) begin
      @(negedge clk_i);
      ready_i = ($urandom_range(0, 3) != 0);
      if (sent < 1000) begin
        valid_i = ($urandom_range(0, 3) != 0);
        a_i = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom);
        case ($urandom_range(0, 9))
          0:       b_i = 12'd0;
          1, 2:    b_i = 12'($urandom_range(1, 15));
          default: b_i = 12'($urandom);
        endcase
      end else begin
        valid_i = 1'b0;
      end
      #1;
      if (valid_o === 1'b1 && ready_i) begin
        got = {data_o, rem_o, dbz_o};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra got q=%h r=%h dbz=%b want no result", data_o, rem_o, dbz_o);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL b2b_result[%0d] got q=%h r=%h dbz=%b want q=%h r=%h dbz=%b", recv, data_o, rem_o, dbz_o, e.q, e.r, e.dbz);
          end
        end
        recv++;
      end
      if (valid_i && ready_o === 1'b1) begin
        exp_q.push_back(model(a_i, b_i));
        sent++;
      end
      @(posedge clk_i);
      cycles++;
    end
    valid_i = 1'b0;
    checks++; if (recv != 1000) begin errors++; $display("FAIL b2b_count got %0d want 1000", recv); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_leftover got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bigdiv.md
BIGDIV -- requirements
Module: bigdiv

Interface
REQ-001 Parameter int_in_lp, 10: integer bits of dividend (accumulator format).
REQ-002 Parameter frac_in_lp, 22: fraction bits of dividend.
REQ-003 Parameter int_div_lp, 1: integer bits of divisor.
REQ-004 Parameter frac_div_lp, 11: fraction bits of divisor.
REQ-005 Parameter int_out_lp, 21: integer bits of quotient.
REQ-006 Parameter frac_out_lp, 11: fraction bits of quotient.
REQ-007 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-008 reset_i  input  1  reset; synchronous and active-high.
REQ-009 a_i  input  [int_in_lp-1:-frac_in_lp]  unsigned fixed-point dividend.
REQ-010 b_i  input  [int_div_lp-1:-frac_div_lp]  unsigned fixed-point divisor.
REQ-011 valid_i  input  1  a_i/b_i valid.
REQ-012 ready_o  output  1  block accepts an operand pair this cycle.
REQ-013 valid_o  output  1  data_o/rem_o/dbz_o valid.
REQ-014 ready_i  input  1  downstream accepts the result.
REQ-015 data_o  output  [int_out_lp-1:-frac_out_lp]  unsigned quotient.
REQ-016 rem_o  output  [int_div_lp-1:-frac_div_lp]  remainder, divisor scale.
REQ-017 dbz_o  output  1  result is from a zero divisor.

Function
REQ-018 Raw-integer arithmetic SHALL apply: data_o_raw = floor(a_raw / b_raw), rem_o_raw = a_raw mod b_raw; the formats make this exact, e.g. Q10.22 / Q1.11 -> Q21.11.
REQ-019 The divider SHALL be radix-2 restoring, one quotient bit per clk_i cycle, MSB first, with a partial remainder one bit wider than b_i.
REQ-020 FSM states: IDLE, BUSY, DONE.
REQ-021 IDLE: ready_o=1; on valid_i&&ready_o, latch a_i/b_i, clear remainder, load counter = dividend width - 1, go to BUSY (or to DONE if b_i==0).
REQ-022 BUSY: ready_o=0, valid_o=0; a_i/b_i/valid_i are ignored; each cycle shift in one dividend bit, subtract the divisor when the remainder is >= divisor, record the quotient bit; at counter==0 go to DONE.
REQ-023 Latency SHALL be fixed: valid_o rises exactly 33 cycles after the accept edge for 32-bit dividends (W+1 generally), and exactly 1 cycle after it for b_i==0.
REQ-024 DONE: valid_o=1; data_o/rem_o/dbz_o SHALL stay stable while ready_i=0, for any number of cycles.
REQ-025 DONE with ready_i=1: ready_o=1 (pass-through); with valid_i=1 as well, accept a new pair on that edge and go to BUSY/DONE as in IDLE, with no bubble; otherwise go to IDLE.
REQ-026 b_i==0: data_o = all ones, rem_o = 0, dbz_o = 1; dbz_o = 0 for every other result.
REQ-027 a_i==0: data_o=0 and rem_o=0 after full latency (no early exit).
REQ-028 Outputs SHALL hold their last values in IDLE; only valid_o qualifies them.

Reset
REQ-029 When reset_i=1 at a clk_i edge, state SHALL become IDLE and valid_o, data_o, rem_o, dbz_o and the counter SHALL be 0, regardless of state (including mid-BUSY).
REQ-030 The first cycle after reset SHALL have ready_o=1; an in-flight operation SHALL be discarded, never emitted.

Structure
REQ-031 A shared package bigdiv_pkg SHALL hold the FSM state enum (IDLE/BUSY/DONE) and the default width localparams.
REQ-032 One sub-module, div_step, SHALL implement the combinational shift/compare/subtract step; the FSM, counter and registers live in bigdiv.
REQ-033 No DSP/SB_MAC16 primitives; fabric logic only, total 120-400 lines.

Verification
REQ-034 a_i=0x0060_0000 (1.5), b_i=0x400 (0.5), ready_i=1 -> valid_o exactly 33 cycles after the accept edge, data_o=0x0000_1800 (3.0), rem_o=0, dbz_o=0.
REQ-035 a_i=0xFFFF_FFFF, b_i=0x001 -> data_o=0xFFFF_FFFF, rem_o=0; a_i=0x0000_0C00, b_i=0x800 -> data_o=1, rem_o=0x400.
REQ-036 b_i=0, any a_i -> valid_o one cycle after the accept edge, data_o=0xFFFF_FFFF, rem_o=0, dbz_o=1.
REQ-037 Hold ready_i=0 for 10 cycles in DONE -> outputs constant and ready_o=0; then ready_i=1 with valid_i=1 -> new pair accepted on the same edge, no idle cycle.
REQ-038 Assert reset_i at BUSY cycle 15 -> next cycle ready_o=1, valid_o=0, data_o=0; the aborted result is never emitted.
REQ-039 Random back-to-back stream (1000 pairs, random ready_i) vs. reference model -> every result matches, in order, with no loss or duplication.
